// File: rtl/block_check_arbiter_pkg.sv
// block_check_arbiter_pkg: shared state encodings and character constants
package block_check_arbiter_pkg;
  typedef enum logic [1:0] {ARB, BUSY, DONE} state_e;
  typedef enum logic [3:0] {START, B, BE, BEG, BEGI, BEGIN, E, EN, END, OTHER} match_e;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] TERM_DEFAULT = 8'h2E;
endpackage

// File: rtl/block_check_arbiter_nest_tracker.sv
// nest_tracker: matches begin/end words and tracks nesting depth with a sticky error
module nest_tracker
  import block_check_arbiter_pkg::*;
#(
  parameter int DEPTH_W = 8,
  parameter logic [7:0] TERM = TERM_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ch,
  input  logic       char_en,
  input  logic       clear,
  output logic       ok_next
);
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic err_q, err_d;
  match_e m_q, m_d;
  logic [7:0] lc;
  logic sep, inc, dec;
  // word matcher step, depth update and next-cycle verdict
  always_comb begin
    lc = ch | 8'h20;
    sep = ch == SPACE || ch == TERM;
    inc = char_en && sep && m_q == BEGIN;
    dec = char_en && sep && m_q == END;
    depth_d = depth_q;
    err_d = err_q;
    m_d = m_q;
    if (char_en && sep) m_d = START;
    else if (char_en)
      case (m_q)
        START:   m_d = lc == "b" ? B : lc == "e" ? E : OTHER;
        B:       m_d = lc == "e" ? BE : OTHER;
        BE:      m_d = lc == "g" ? BEG : OTHER;
        BEG:     m_d = lc == "i" ? BEGI : OTHER;
        BEGI:    m_d = lc == "n" ? BEGIN : OTHER;
        E:       m_d = lc == "n" ? EN : OTHER;
        EN:      m_d = lc == "d" ? END : OTHER;
        default: m_d = OTHER;
      endcase
    if (inc && &depth_q) err_d = 1'b1;
    else if (inc) depth_d = depth_q + DEPTH_W'(1);
    if (dec && depth_q == '0) err_d = 1'b1;
    else if (dec) depth_d = depth_q - DEPTH_W'(1);
    ok_next = depth_d == '0 && !err_d;
    if (clear) begin
      depth_d = '0;
      err_d = 1'b0;
      m_d = START;
    end
  end
  // matcher and depth registers
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      err_q <= 1'b0;
      m_q <= START;
    end else begin
      depth_q <= depth_d;
      err_q <= err_d;
      m_q <= m_d;
    end
  end
endmodule

// File: rtl/block_check_arbiter.sv
// block_check_arbiter: two-requester sentence arbiter with begin/end balance verdicts
module block_check_arbiter
  import block_check_arbiter_pkg::*;
#(
  parameter int DEPTH_W = 8,
  parameter logic [7:0] TERM = TERM_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic       in0_valid,
  input  logic       in1_valid,
  output logic       in0_ready,
  output logic       in1_ready,
  output logic       res_valid,
  output logic       res_ok,
  output logic       res_id,
  output logic       busy
);
  state_e state_q, state_d;
  logic grant_q, grant_d, last_id_q, last_id_d;
  logic res_ok_q, res_ok_d, res_id_q, res_id_d;
  logic [7:0] ch;
  logic acc, ok_next;
  // arbitration, sentence FSM and handshake outputs
  always_comb begin
    busy = state_q == BUSY;
    res_valid = state_q == DONE;
    res_ok = res_ok_q;
    res_id = res_id_q;
    in0_ready = busy && !grant_q;
    in1_ready = busy && grant_q;
    ch = grant_q ? in1 : in0;
    acc = busy && (grant_q ? in1_valid : in0_valid);
    state_d = state_q;
    grant_d = grant_q;
    last_id_d = last_id_q;
    res_ok_d = res_ok_q;
    res_id_d = res_id_q;
    case (state_q)
      ARB: if (in0_valid || in1_valid) begin
        grant_d = in0_valid && in1_valid ? !last_id_q : in1_valid;
        last_id_d = grant_d;
        state_d = BUSY;
      end
      BUSY: if (acc && ch == TERM) begin
        res_ok_d = ok_next;
        res_id_d = grant_q;
        state_d = DONE;
      end
      default: state_d = ARB;
    endcase
  end
  // FSM and verdict registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      grant_q <= 1'b0;
      last_id_q <= 1'b1;
      res_ok_q <= 1'b0;
      res_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_id_q <= last_id_d;
      res_ok_q <= res_ok_d;
      res_id_q <= res_id_d;
    end
  end
  nest_tracker #(.DEPTH_W(DEPTH_W), .TERM(TERM)) u_nest (
    .clk(clk),
    .reset(reset),
    .ch(ch),
    .char_en(acc),
    .clear(res_valid),
    .ok_next(ok_next)
  );
endmodule

// File: tb/tb_block_check_arbiter.sv
// tb_block_check_arbiter: table-driven sentence vectors with a verdict scoreboard
module tb_block_check_arbiter;
  import block_check_arbiter_pkg::*;
  typedef struct {logic ok; logic id;} exp_t;
  typedef struct {logic id; string s; logic ok;} vec_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] in0 = 8'h00, in1 = 8'h00, s_in = 8'h00;
  logic in0_valid = 1'b0, in1_valid = 1'b0, s_valid = 1'b0;
  logic in0_ready, in1_ready, res_valid, res_ok, res_id, busy;
  logic s_in0_ready, s_in1_ready, s_res_valid, s_res_ok, s_res_id, s_busy;
  logic [7:0] q0[$], q1[$], q2[$];
  exp_t sb[$], sb2[$];
  vec_t tbl[7];
  int total = 0, bad = 0;
  logic a0 = 1'b0, a1 = 1'b0, a2 = 1'b0, tp = 1'b0, tp2 = 1'b0, rnd2 = 1'b0;

  always #5 clk = ~clk;

  block_check_arbiter u_dut (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1),
    .in0_valid(in0_valid), .in1_valid(in1_valid),
    .in0_ready(in0_ready), .in1_ready(in1_ready),
    .res_valid(res_valid), .res_ok(res_ok), .res_id(res_id), .busy(busy)
  );

  block_check_arbiter #(.DEPTH_W(2)) u_small (
    .clk(clk), .reset(reset), .in0(s_in), .in1(8'h00),
    .in0_valid(s_valid), .in1_valid(1'b0),
    .in0_ready(s_in0_ready), .in1_ready(s_in1_ready),
    .res_valid(s_res_valid), .res_ok(s_res_ok), .res_id(s_res_id), .busy(s_busy)
  );

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic put(int lane, string s);
    for (int i = 0; i < s.len(); i++)
      if (lane == 0) q0.push_back(s[i]);
      else if (lane == 1) q1.push_back(s[i]);
      else q2.push_back(s[i]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size() + sb.size() + sb2.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL timeout: got pending=%0d expected 0", sb.size() + sb2.size());
      q0.delete(); q1.delete(); q2.delete(); sb.delete(); sb2.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // driver and monitor: outputs checked, then queues advanced and inputs re-driven each negedge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tp || res_valid) chk("verdict_latency", res_valid, tp);
      if (tp2 || s_res_valid) chk("small_verdict_latency", s_res_valid, tp2);
      if (res_valid) begin
        if (sb.size() == 0) chk("unexpected_verdict", res_valid, 0);
        else begin
          e = sb.pop_front();
          chk("res_ok", res_ok, e.ok);
          chk("res_id", res_id, e.id);
        end
      end
      if (s_res_valid) begin
        if (sb2.size() == 0) chk("small_unexpected_verdict", s_res_valid, 0);
        else begin
          e = sb2.pop_front();
          chk("small_res_ok", s_res_ok, e.ok);
        end
      end
      if (in0_ready || in1_ready) begin
        chk("one_ready", in0_ready && in1_ready, 0);
        chk("busy_when_ready", busy, 1);
      end
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
      if (a2) void'(q2.pop_front());
      in0_valid = q0.size() != 0;
      in0 = in0_valid ? q0[0] : 8'h00;
      in1_valid = q1.size() != 0;
      in1 = in1_valid ? q1[0] : 8'h00;
      s_valid = q2.size() != 0 && (!rnd2 || $urandom_range(1) == 1);
      s_in = q2.size() != 0 ? q2[0] : 8'h00;
      a0 = in0_valid && in0_ready;
      a1 = in1_valid && in1_ready;
      a2 = s_valid && s_in0_ready;
      tp = (a0 && in0 == TERM_DEFAULT) || (a1 && in1 == TERM_DEFAULT);
      tp2 = a2 && s_in == TERM_DEFAULT;
    end
  end

  initial begin
    int n;
    tbl[0] = '{1'b0, "begin end.", 1'b1};
    tbl[1] = '{1'b0, "BeGin eNd end.", 1'b0};
    tbl[2] = '{1'b0, ".", 1'b1};
    tbl[3] = '{1'b0, "endc  begins   be.", 1'b1};
    tbl[4] = '{1'b1, "begin begin end END.", 1'b1};
    tbl[5] = '{1'b1, " begin  END .", 1'b1};
    tbl[6] = '{1'b0, "begin.", 1'b0};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_outputs", {res_valid, res_ok, res_id, busy, in0_ready, in1_ready}, 0);
    chk("small_reset_outputs", {s_res_valid, s_res_ok, s_res_id, s_busy, s_in0_ready, s_in1_ready}, 0);
    @(negedge clk);
    chk("idle_stays_arb", {busy, in0_ready, in1_ready}, 0);
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{tbl[i].ok, tbl[i].id});
      put(int'(tbl[i].id), tbl[i].s);
      wait_idle();
    end
    pulse_reset();
    sb.push_back('{1'b1, 1'b0});
    sb.push_back('{1'b0, 1'b1});
    sb.push_back('{1'b1, 1'b0});
    sb.push_back('{1'b0, 1'b1});
    put(0, "a.a.");
    put(1, "begin.begin.");
    wait_idle();
    put(0, "begin begin");
    n = 0;
    while (q0.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("partial_sentence_drained", q0.size(), 0);
    repeat (2) @(negedge clk);
    chk("busy_mid_sentence", busy, 1);
    pulse_reset();
    chk("after_reset_outputs", {res_valid, busy, in0_ready, in1_ready}, 0);
    sb.push_back('{1'b0, 1'b1});
    put(1, "end .");
    wait_idle();
    sb2.push_back('{1'b0, 1'b0});
    put(2, "begin begin begin begin end end end end.");
    wait_idle();
    rnd2 = 1'b1;
    sb2.push_back('{1'b0, 1'b0});
    put(2, "begin begin begin begin end end end end.");
    wait_idle();
    sb2.push_back('{1'b1, 1'b0});
    put(2, "begin begin begin end end end.");
    wait_idle();
    rnd2 = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/block_check_arbiter.md
BLOCK_CHECK_ARBITER -- requirements
Module: block_check_arbiter

Interface
REQ-001 Parameter: DEPTH_W, 8, width of the nesting-depth counter.
REQ-002 Parameter: TERM, 8'h2E ('.'), sentence terminator character.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in0 / in1  input  8 each  ASCII character from requester 0 / 1.
REQ-006 Port: in0_valid / in1_valid  input  1 each  requester has a character on its in bus.
REQ-007 Port: in0_ready / in1_ready  output  1 each  block accepts that requester's character this cycle.
REQ-008 Port: res_valid  output  1  one-cycle pulse; a sentence verdict is present.
REQ-009 Port: res_ok  output  1  verdict: 1 means begin/end are balanced and never underflowed.
REQ-010 Port: res_id  output  1  requester that owns the verdict.
REQ-011 Port: busy  output  1  a sentence is granted and not yet terminated.

Function
REQ-012 States SHALL be ARB, BUSY and DONE; the reset state SHALL be ARB.
REQ-013 ARB: if any inX_valid, grant SHALL be registered, the state SHALL go to BUSY and last_id SHALL be updated.
REQ-014 ARB arbitration: single valid wins; both valid -> requester != last_id wins; none valid -> stay in ARB.
REQ-015 BUSY: inX_ready = (grant==X), combinational; the non-granted ready SHALL be 0; in ARB/DONE both readies SHALL be 0.
REQ-016 A character SHALL be accepted only on a cycle with inX_valid && inX_ready; valid without ready SHALL have no effect.
REQ-017 Characters SHALL be split into words by space (8'h20) or TERM; empty words from consecutive separators SHALL be ignored.
REQ-018 Letters SHALL compare case-insensitively (fold via bit 5); a word equal to "begin" SHALL increment depth; "end" SHALL decrement depth; any other word, including "endc", "begins" and "be", SHALL have no effect.
REQ-019 A decrement at depth 0, or an increment at depth 2^DEPTH_W-1, SHALL set a sticky error flag; depth SHALL then hold its value.
REQ-020 On acceptance of TERM: the final word SHALL be evaluated; res_ok = (depth_next==0 && !err_next) SHALL be registered; res_id = grant; state -> DONE.
REQ-021 DONE (exactly one cycle): res_valid=1; depth, error and word-matcher state SHALL be cleared; state -> ARB.
REQ-022 ARB->BUSY takes one cycle; verdict latency SHALL be 1 cycle after the TERM acceptance edge; a sentence start-to-start overhead of 2 idle cycles (DONE, ARB) is required.
REQ-023 busy SHALL be 1 exactly in BUSY.
REQ-024 A sentence SHALL never be interleaved with the other requester's characters.

Reset
REQ-025 Reset SHALL override all other activity in the same cycle.
REQ-026 Reset values: state=ARB, last_id=1 (requester 0 first), depth=0, error=0, matcher=start-of-word, res_valid=0, res_ok=0, res_id=0, busy=0, both readies=0.
REQ-027 A reset mid-sentence SHALL discard the partial sentence and emit no verdict.

Structure
REQ-028 A shared package SHALL hold the state encoding (ARB/BUSY/DONE), the matcher states (START, B, BE, BEG, BEGI, BEGIN, E, EN, END, OTHER) and the constants SPACE=8'h20 and TERM_DEFAULT=8'h2E.
REQ-029 Word matching and depth/error tracking SHALL be one sub-module, nest_tracker (inputs: char, char_en, clear; outputs: next-state ok verdict), instantiated once; arbitration and the FSM SHALL stay in the top.

Verification
REQ-030 After reset, in0 streams "begin end." with in1 idle -> one res_valid pulse, res_ok=1, res_id=0, 1 cycle after the '.' is accepted.
REQ-031 in0 streams "BeGin eNd end." -> res_ok=0 (underflow); the next in0 sentence "." -> res_ok=1 (error cleared).
REQ-032 in0 and in1 valid from reset, each with repeating sentences "a." and "begin." -> verdict order res_id 0,1,0,1 with res_ok 1,0,1,0; in1_ready stays 0 during requester 0's sentence.
REQ-033 in0 streams "endc  begins   be." (multiple spaces) -> res_ok=1.
REQ-034 in0 streams "begin begin" then reset is pulsed for 1 cycle, then in1 streams "end ." -> no verdict before reset; after reset, requester 1 is granted; result res_ok=0, res_id=1.
REQ-035 With DEPTH_W=2, in0 streams "begin" x4 followed by "end" x4 and "." -> res_ok=0 (overflow sticky); in0_valid toggled randomly -> same verdict.
